// File: rtl/case_1_sdiv_pkg.sv
// rtl/case_1_sdiv_pkg.sv - shared types and default widths for the sequential signed divider
package case_1_sdiv_pkg;

    localparam int DIN0_W = 9;
    localparam int DIN1_W = 4;
    localparam int DOUT_W = 9;
    localparam int CNT_W  = $clog2(DIN0_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/case_1_sdiv_step.sv
// rtl/case_1_sdiv_step.sv - one combinational radix-2 restoring division step
module case_1_sdiv_step
    import case_1_sdiv_pkg::*;
#(
    parameter int DW = DIN1_W
) (
    input  logic [DW:0]   prem,
    input  logic          nbit,
    input  logic [DW-1:0] dvs,
    output logic [DW:0]   prem_next,
    output logic          qbit
);

    logic [DW+1:0] shifted;
    logic [DW:0]   diff_lo;

    // The low bits of the difference are only used when the trial
    // subtraction succeeds, so a modular subtract is exact there.
    always_comb begin
        shifted   = {prem, nbit};
        qbit      = (shifted >= {2'b00, dvs});
        diff_lo   = shifted[DW:0] - {1'b0, dvs};
        prem_next = qbit ? diff_lo : shifted[DW:0];
    end

endmodule

// File: rtl/case_1_sdiv_9s_4s_9_seq.sv
// rtl/case_1_sdiv_9s_4s_9_seq.sv - sequential signed divider, start/done with ce stall; option SDIV_DBZ_FASTPATH_EN
module case_1_sdiv_9s_4s_9_seq
    import case_1_sdiv_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(din0_WIDTH + 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [din0_WIDTH-1:0] dvd;
    logic [din1_WIDTH:0]   prem;
    logic [din1_WIDTH-1:0] dvs;
    logic [din1_WIDTH-1:0] din0_lo;
    logic                  sign_q;
    logic                  sign_r;
    logic                  dbz;

    logic [din1_WIDTH:0]   prem_next;
    logic                  qbit;

    case_1_sdiv_step #(.DW(din1_WIDTH)) u_step (
        .prem      (prem),
        .nbit      (dvd[din0_WIDTH-1]),
        .dvs       (dvs),
        .prem_next (prem_next),
        .qbit      (qbit)
    );

    // dvd starts as |dividend| and fills with quotient bits from the LSB,
    // so after din0_WIDTH steps it holds the unsigned quotient.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            prem        <= '0;
            dvs         <= '0;
            din0_lo     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        sign_r  <= din0[din0_WIDTH-1];
                        dvd     <= din0[din0_WIDTH-1] ? -din0 : din0;
                        dvs     <= din1[din1_WIDTH-1] ? -din1 : din1;
                        din0_lo <= din0[din1_WIDTH-1:0];
                        dbz     <= (din1 == '0);
                        prem    <= '0;
                        cnt     <= CW'(din0_WIDTH);
                        busy    <= 1'b1;
`ifdef SDIV_DBZ_FASTPATH_EN
                        state   <= (din1 == '0) ? FIX : CALC;
`else
                        state   <= CALC;
`endif
                    end
                end
                CALC: begin
                    dvd  <= {dvd[din0_WIDTH-2:0], qbit};
                    prem <= prem_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    if (dbz) begin
                        quot <= '1;
                        rem  <= din0_lo;
                    end else begin
                        quot <= dout_WIDTH'(sign_q ? -dvd : dvd);
                        rem  <= sign_r ? -prem[din1_WIDTH-1:0] : prem[din1_WIDTH-1:0];
                    end
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_case_1_sdiv_9s_4s_9_seq.sv
// tb/tb_case_1_sdiv_9s_4s_9_seq.sv - self-checking bench for the sequential signed divider
module tb_case_1_sdiv_9s_4s_9_seq;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       start;
    logic [8:0] din0;
    logic [3:0] din1;
    logic       busy;
    logic       done;
    logic [8:0] quot;
    logic [3:0] rem;
    logic       div_by_zero;

    int tests;
    int fails;

    case_1_sdiv_9s_4s_9_seq dut (
        .ap_clk      (clk),
        .ap_rst_n    (rst_n),
        .ce          (ce),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [8:0] a, input logic [3:0] b,
                                    output logic [8:0] q, output logic [3:0] r,
                                    output logic dz);
        int ia, ib, iq, ir;
        ia = $signed(a);
        ib = $signed(b);
        if (ib == 0) begin
            q  = 9'h1FF;
            r  = a[3:0];
            dz = 1'b1;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q  = iq[8:0];
            r  = ir[3:0];
            dz = 1'b0;
        end
    endfunction

    function automatic int ref_lat(input logic [3:0] b);
`ifdef SDIV_DBZ_FASTPATH_EN
        return (b == 4'd0) ? 1 : 10;
`else
        return 10;
`endif
    endfunction

    // Runs one operation; counts edges after the accepting edge until done.
    task automatic do_op(input logic [8:0] a, input logic [3:0] b,
                         input int stall_from, input int stall_len, input int junk_at,
                         output logic [8:0] q, output logic [3:0] r, output logic dz,
                         output int lat, output bit busy_ok, output logic busy_at_done);
        @(negedge clk);
        din0 = a; din1 = b; start = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din0 = 9'($urandom); din1 = 4'($urandom);
        lat = -1; busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            ce = (n >= stall_from && n < stall_from + stall_len) ? 1'b0 : 1'b1;
            start = (n == junk_at);
            if (start) begin
                din0 = 9'($urandom); din1 = 4'($urandom_range(1, 15));
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0; ce = 1'b1;
        q = quot; r = rem; dz = div_by_zero; busy_at_done = busy;
    endtask

    task automatic check_op(input string name, input logic [8:0] a, input logic [3:0] b,
                            input int stall_from, input int stall_len, input int junk_at,
                            input int extra_lat);
        logic [8:0] q, eq;
        logic [3:0] r, er;
        logic dz, edz, bd;
        int lat, elat;
        bit bok;
        ref_div(a, b, eq, er, edz);
        elat = ref_lat(b) + extra_lat;
        do_op(a, b, stall_from, stall_len, junk_at, q, r, dz, lat, bok, bd);
        tests++;
        if (lat !== elat || q !== eq || r !== er || dz !== edz || !bok || bd !== 1'b0) begin
            fails++;
            $display("FAIL %s a=%0d b=%0d: got lat=%0d quot=%h rem=%h dbz=%b busy_ok=%b busy@done=%b; want lat=%0d quot=%h rem=%h dbz=%b busy_ok=1 busy@done=0",
                     name, $signed(a), $signed(b), lat, q, r, dz, bok, bd, elat, eq, er, edz);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || quot !== 9'd0 || rem !== 4'd0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset: got busy=%b done=%b quot=%h rem=%h dbz=%b; want all 0",
                     busy, done, quot, rem, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        check_op("pos_pos",   9'd100,          4'd7,          0, 0, 0, 0);
        check_op("neg_pos",   9'(-100),        4'd7,          0, 0, 0, 0);
        check_op("pos_neg",   9'd127,          4'(-8),        0, 0, 0, 0);
        check_op("ovf",       9'(-256),        4'(-1),        0, 0, 0, 0);
        check_op("min_by_1",  9'(-256),        4'd1,          0, 0, 0, 0);
        check_op("div_zero",  9'd5,            4'd0,          0, 0, 0, 0);
        check_op("neg_zero",  9'(-3),          4'd0,          0, 0, 0, 0);
        check_op("small",     9'd3,            4'd7,          0, 0, 0, 0);
    endtask

    task automatic test_hold;
        logic [8:0] eq;
        logic [3:0] er;
        logic edz;
        ref_div(9'(-100), 4'd7, eq, er, edz);
        check_op("hold_op", 9'(-100), 4'd7, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            din0 = 9'($urandom); din1 = 4'($urandom);
            @(posedge clk); #1;
        end
        tests++;
        if (quot !== eq || rem !== er || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold: got quot=%h rem=%h done=%b busy=%b; want quot=%h rem=%h done=0 busy=0",
                     quot, rem, done, busy, eq, er);
        end
    endtask

    task automatic test_ignored_start;
        check_op("start_busy", 9'd100, 4'd7, 0, 0, 3, 0);
        check_op("start_fix",  9'd77,  4'd5, 0, 0, 10, 0);
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_fix_noaccept: got busy=%b; want 0", busy);
        end
    endtask

    task automatic test_stall;
        check_op("stall3", 9'd100, 4'd7, 4, 3, 0, 3);
        check_op("stall1", 9'(-77), 4'(-3), 9, 1, 0, 1);
    endtask

    task automatic test_mid_reset;
        bit seen;
        check_op("pre_reset", 9'd127, 4'(-8), 0, 0, 0, 0);
        @(negedge clk);
        din0 = 9'd100; din1 = 4'd7; start = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || quot !== 9'd0 || rem !== 4'd0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got busy=%b done=%b quot=%h rem=%h dbz=%b; want all 0",
                     busy, done, quot, rem, div_by_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL mid_reset_no_done: got done/busy activity=1; want 0");
        end
        check_op("post_reset", 9'd45, 4'(-6), 0, 0, 0, 0);
    endtask

    task automatic test_random;
        logic [8:0] a;
        logic [3:0] b;
        for (int i = 0; i < 40; i++) begin
            a = 9'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            check_op("random", a, b, 0, 0, 0, 0);
        end
    endtask

    task automatic test_back_to_back;
        check_op("b2b_a", 9'(-255), 4'd2, 0, 0, 0, 0);
        check_op("b2b_b", 9'd255,   4'(-7), 0, 0, 0, 0);
        check_op("b2b_c", 9'(-1),   4'd0, 0, 0, 0, 0);
        check_op("b2b_d", 9'(-8),   4'(-8), 0, 0, 0, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_hold();
        test_ignored_start();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/case_1_sdiv_9s_4s_9_seq.md
Name: case_1_sdiv_9s_4s_9_seq

Overview:
Sequential signed integer divider: quotient = din0 / din1 and remainder = din0 % din1, using C truncating semantics. It is the inverse companion of the combinational 9s×4s signed multiplier core in the same HLS-generated datapath. It is one radix-2 restoring step per cycle, under a start/done handshake with clock-enable stall. Instantiated by HLS-scheduled FSMs wherever a division op appears.

Parameters:
din0_WIDTH, 9, dividend width (signed)
din1_WIDTH, 4, divisor width (signed)
dout_WIDTH, 9, quotient width (signed); equals din0_WIDTH

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; low freezes all state and outputs
start  in  1  sampled in IDLE with ce=1; launches an operation
din0  in  din0_WIDTH  signed dividend, captured on accepted start
din1  in  din1_WIDTH  signed divisor, captured on accepted start
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse; results valid from this cycle on
quot  out  dout_WIDTH  signed quotient, held until next done
rem  out  din1_WIDTH  signed remainder, held until next done
div_by_zero  out  1  set with done when captured din1 == 0; held with results

Behaviour:
- Reset (async assert, sync deassert internal): state=IDLE; busy=0, done=0, quot=0, rem=0, div_by_zero=0, counter=0.
- States: IDLE -> CALC on start&ce; CALC -> FIX when counter reaches 0; FIX -> IDLE unconditionally. FIX registers outputs and pulses done.
- On accept: latch sign_q = sign(din0)^sign(din1) and sign_r = sign(din0). Latch |din0| as din0_WIDTH-bit unsigned; |−256| = 256 fits. Latch |din1| as din1_WIDTH-bit unsigned.
- Set counter = din0_WIDTH and partial remainder (din1_WIDTH+1 bits) = 0.
- CALC, each ce cycle:
  - shift the next dividend MSB into the partial remainder;
  - trial-subtract |divisor|;
  - if non-negative, keep the difference and set the quotient bit to 1, else 0;
  - decrement counter.
- Latency: done asserts exactly din0_WIDTH+1 enabled cycles after the accepting edge (10 for defaults). ce=0 cycles add 1:1.
- Sign fix in FIX:
  - quot = sign_q ? −Q : Q, truncated to dout_WIDTH (two's-complement wrap).
  - rem = sign_r ? −R : R; |rem| ≤ 7 always fits.
- Overflow: −256 / −1 yields quot = −256 (0x100), rem = 0, and no flag.
- Divide by zero: run the full latency. quot = all ones, rem = din0[din1_WIDTH-1:0], div_by_zero = 1.
- start while busy or in FIX: ignored, no queueing. start in the same cycle as done (FIX) is ignored; accept resumes in IDLE next cycle.
- din0/din1 may change after accept without effect.
- Reset mid-operation: immediate abort to reset values; no done pulse.

Optional Feature:
SDIV_DBZ_FASTPATH_EN
- Defined: a zero divisor detected at accept skips CALC and goes IDLE -> FIX. done asserts 1 enabled cycle after accept, with the same result values as above.
- Undefined: fixed latency for all operands.

Decomposition:
- Package case_1_sdiv_pkg: state enum {IDLE, CALC, FIX}; default width constants; counter width constant $clog2(din0_WIDTH+1).
- Sub-module case_1_sdiv_step: combinational single restoring step. Inputs: partial remainder, next dividend bit, |divisor|. Outputs: next remainder and quotient bit.
- Top module holds the FSM, counter, operand and sign registers, and output registers.

Test Plan:
- 100 / 7: done at accept+10, quot=14, rem=2, div_by_zero=0; busy high for cycles 1–9 and low with done.
- −100 / 7: quot=−14 (0x1F2), rem=−2 (0xE). 127 / −8: quot=−15, rem=7.
- −256 / −1: quot=0x100, rem=0, div_by_zero=0. −256 / 1: quot=−256, rem=0.
- 5 / 0: quot=0x1FF, rem=5, div_by_zero=1; done at +10, or at +1 with SDIV_DBZ_FASTPATH_EN.
- start pulsed during busy with different operands: ignored, first result intact. ce=0 for 3 mid-CALC cycles: done at +13, same result.
- ap_rst_n low at CALC cycle 4: all outputs 0 asynchronously, no done. Next op 45 / −6 gives quot=−7, rem=3.
